// File: rtl/cpu_pkg.sv
// Shared CPU constants for the fetch stage: data width, canonical NOP and default boot PC.
package cpu_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; sticks at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] cnt_r;

    // Count qualified events until saturation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {W{1'b0}};
        end else if (inc_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC selection from predictor controls, IF/ID register
// and branch/mispredict statistics counters.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_br_i,
    input  logic             hit_i,
    input  logic [31:0]      npc_i,
    input  logic             br_resolve_EX_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_rdata_i,
    output logic [31:0]      pc_IF_o,
    output logic [31:0]      instr_IF_o,
    output logic [31:0]      pc_ID_o,
    output logic [31:0]      instr_ID_o,
    output logic             valid_ID_o,
    output logic             pred_taken_ID_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_id_r;
    logic [XLEN-1:0] instr_id_r;
    logic            valid_id_r;
    logic            pred_taken_id_r;
    logic [XLEN-1:0] next_pc_s;
    logic            br_inc_s;

    // Next-PC priority: redirect on mispredict, hold on stall, predicted target, sequential
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        if (flush_br_i) begin
            next_pc_s = npc_i;
        end else if (stall_i) begin
            next_pc_s = pc_r;
        end else if (hit_i) begin
            next_pc_s = npc_i;
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
    end

    // PC and IF/ID register; a flush squashes the wrong-path word even while stalled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r            <= RESET_PC;
            pc_id_r         <= 32'h0000_0000;
            instr_id_r      <= NOP_INSTR;
            valid_id_r      <= 1'b0;
            pred_taken_id_r <= 1'b0;
        end else begin
            pc_r <= next_pc_s;
            if (flush_br_i) begin
                pc_id_r         <= pc_id_r;
                instr_id_r      <= NOP_INSTR;
                valid_id_r      <= 1'b0;
                pred_taken_id_r <= 1'b0;
            end else if (stall_i) begin
                pc_id_r         <= pc_id_r;
                instr_id_r      <= instr_id_r;
                valid_id_r      <= valid_id_r;
                pred_taken_id_r <= pred_taken_id_r;
            end else begin
                pc_id_r         <= pc_r;
                instr_id_r      <= imem_rdata_i;
                valid_id_r      <= 1'b1;
                pred_taken_id_r <= hit_i;
            end
        end
    end

    assign br_inc_s = br_resolve_EX_i && !stall_i;

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (br_inc_s),
        .cnt_o (br_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_br_i),
        .cnt_o (mispred_cnt_o)
    );

    assign imem_addr_o     = pc_r;
    assign pc_IF_o         = pc_r;
    assign instr_IF_o      = imem_rdata_i;
    assign pc_ID_o         = pc_id_r;
    assign instr_ID_o      = instr_id_r;
    assign valid_ID_o      = valid_id_r;
    assign pred_taken_ID_o = pred_taken_id_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with 4-bit counters so saturation is reachable quickly.
module tb_fetch_pc_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, flush, hit, br_res;
    logic [31:0] npc;
    logic [31:0] imem_addr, imem_rdata, pc_if, instr_if, pc_id, instr_id;
    logic        valid_id, pred_id;
    logic [3:0]  br_cnt, mis_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word is its address xor a fixed key
    assign imem_rdata = imem_addr ^ KEY;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .flush_br_i      (flush),
        .hit_i           (hit),
        .npc_i           (npc),
        .br_resolve_EX_i (br_res),
        .imem_addr_o     (imem_addr),
        .imem_rdata_i    (imem_rdata),
        .pc_IF_o         (pc_if),
        .instr_IF_o      (instr_if),
        .pc_ID_o         (pc_id),
        .instr_ID_o      (instr_id),
        .valid_ID_o      (valid_id),
        .pred_taken_ID_o (pred_id),
        .br_cnt_o        (br_cnt),
        .mispred_cnt_o   (mis_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; hit = 1'b0; br_res = 1'b0; npc = 32'h0;
        step(); step();
        check("rst_pc", pc_if, 32'h0);
        check("rst_valid", {31'b0, valid_id}, 32'h0);
        check("rst_instr", instr_id, NOP);
        check("rst_pc_id", pc_id, 32'h0);
        check("rst_pred", {31'b0, pred_id}, 32'h0);
        check("rst_br", {28'b0, br_cnt}, 32'h0);
        check("rst_mis", {28'b0, mis_cnt}, 32'h0);

        rst = 1'b0;
        step();
        check("seq1_pc", pc_if, 32'h4);
        check("seq1_instr_if", instr_if, 32'hA5A5_0004);
        check("seq1_pc_id", pc_id, 32'h0);
        check("seq1_instr_id", instr_id, 32'hA5A5_0000);
        check("seq1_valid", {31'b0, valid_id}, 32'h1);
        step();
        check("seq2_pc", pc_if, 32'h8);
        check("seq2_pc_id", pc_id, 32'h4);

        hit = 1'b1; npc = 32'h100; br_res = 1'b1;
        step();
        check("hit_pc", pc_if, 32'h100);
        check("hit_pc_id", pc_id, 32'h8);
        check("hit_pred", {31'b0, pred_id}, 32'h1);
        check("hit_instr_id", instr_id, 32'hA5A5_0008);
        check("hit_br", {28'b0, br_cnt}, 32'h1);

        hit = 1'b0; br_res = 1'b0;
        step();
        check("seq3_pc", pc_if, 32'h104);
        check("seq3_pc_id", pc_id, 32'h100);
        check("seq3_pred", {31'b0, pred_id}, 32'h0);

        flush = 1'b1; stall = 1'b1; hit = 1'b1; npc = 32'h40; br_res = 1'b1;
        step();
        check("flush_pc", pc_if, 32'h40);
        check("flush_valid", {31'b0, valid_id}, 32'h0);
        check("flush_instr", instr_id, NOP);
        check("flush_pred", {31'b0, pred_id}, 32'h0);
        check("flush_mis", {28'b0, mis_cnt}, 32'h1);
        check("flush_br_stalled", {28'b0, br_cnt}, 32'h1);

        stall = 1'b0; hit = 1'b0; br_res = 1'b0; npc = 32'h1C;
        step();
        check("flush2_pc", pc_if, 32'h1C);
        check("flush2_mis", {28'b0, mis_cnt}, 32'h2);
        flush = 1'b0;
        step();
        check("pre_stall_pc", pc_if, 32'h20);
        check("pre_stall_pc_id", pc_id, 32'h1C);

        stall = 1'b1; br_res = 1'b1; hit = 1'b1; npc = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc_if, 32'h20);
            check("stall_pc_id", pc_id, 32'h1C);
            check("stall_instr_id", instr_id, 32'hA5A5_001C);
            check("stall_valid", {31'b0, valid_id}, 32'h1);
            check("stall_pred", {31'b0, pred_id}, 32'h0);
            check("stall_br", {28'b0, br_cnt}, 32'h1);
        end

        stall = 1'b0; hit = 1'b0; br_res = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("br_sat", {28'b0, br_cnt}, 32'hF);

        br_res = 1'b0; flush = 1'b1; npc = 32'h0;
        for (int i = 0; i < 12; i++) step();
        check("mis_14", {28'b0, mis_cnt}, 32'hE);
        for (int i = 0; i < 3; i++) step();
        check("mis_sat", {28'b0, mis_cnt}, 32'hF);

        npc = 32'hFFFF_FFFC;
        step();
        check("wrap_load", pc_if, 32'hFFFF_FFFC);
        flush = 1'b0;
        step();
        check("wrap_pc", pc_if, 32'h0);
        check("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
        check("wrap_valid", {31'b0, valid_id}, 32'h1);

        flush = 1'b1; npc = 32'h103;
        step();
        check("misalign_pc", pc_if, 32'h103);

        rst = 1'b1; hit = 1'b1; npc = 32'h500; br_res = 1'b1;
        step();
        check("rst_prio_pc", pc_if, 32'h0);
        check("rst_prio_mis", {28'b0, mis_cnt}, 32'h0);
        check("rst_prio_br", {28'b0, br_cnt}, 32'h0);
        check("rst_prio_valid", {31'b0, valid_id}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
